jt12_slot_sched: RTL and testbench
==================================

// Module: jt12_slot_sched
// PURPOSE
//  Operator slot scheduler and modulation operand buffer for the FM operator pipeline. Steps through
//  operator groups S1,S3,S2,S4, each spanning NUM_CH channel slots, and drives the one-hot sN_enters
//  strobes that the modulation decoder consumes. Keeps a per-channel store of recent operator results.
//  Returns the x/y phase-modulation operands selected by the decoder's use flags.
// PARAMETERS
//  NUM_CH  6   channels per operator group (3 or 6); one sample period = 4*NUM_CH slots
//  OP_LAT  4   clk_en cycles from slot issue to its op_result; legal 1..NUM_CH
//  DW      14  operator result / modulation operand width (signed)
// PORTS
//  rst             in   1    synchronous reset, active high
//  clk             in   1    system clock; the block's only clock
//  clk_en          in   1    slot advance enable; all state changes only when clk_en=1
//  op_result       in   DW   signed output of the slot issued OP_LAT clk_en cycles earlier
//  xuse_prevprev1  in   1    decoder flag: x operand = s1_older of current channel
//  xuse_prev2      in   1    decoder flag: x operand = s2_last
//  xuse_internal   in   1    decoder flag: x operand = s3_last
//  yuse_prev1      in   1    decoder flag: y operand = s1_last
//  yuse_prev2      in   1    decoder flag: y operand = s2_last
//  yuse_internal   in   1    decoder flag: y operand = s3_last
//  s1_enters..s4_enters out 1 one-hot current operator group (registered)
//  cur_ch          out  3    current channel index 0..NUM_CH-1 (registered)
//  zero            out  1    high during slot 0 of a sample period (S1, ch0)
//  mod_x, mod_y    out  DW   selected modulation operands for the previous slot (registered)
// BEHAVIOUR
//  - Reset: cur_ch=0, s1_enters=1, s2/s3/s4_enters=0, zero=1, mod_x=mod_y=0; store cleared to 0;
//    in-flight result tracker marked empty. Reset mid-period discards all pending results.
//  - Slot counter: per clk_en, cur_ch increments; at NUM_CH-1 wraps to 0 and group advances
//    S1->S3->S2->S4->S1. zero=1 only at (S1,ch0). clk_en=0 holds every register.
//  - Store per channel: s1_last, s1_older, s2_last, s3_last (DW bits each). S4 results not stored.
//  - Write path: OP_LAT-deep shift register of {valid,group,ch} tagged at slot issue. When clk_en=1
//    and tail valid: S1 -> s1_older<=s1_last, s1_last<=op_result; S2 -> s2_last; S3 -> s3_last.
//    Tracker is empty after reset, so the first OP_LAT clk_en cycles write nothing.
//  - Operand select, registered on clk_en, using current slot's ch and flags (same cycle as enters):
//    x = xuse_prevprev1 ? s1_older : xuse_prev2 ? s2_last : xuse_internal ? s3_last : 0
//    y = yuse_prev1 ? s1_last : yuse_prev2 ? s2_last : yuse_internal ? s3_last : 0
//    Priority order as written; multiple set flags are a decoder error but resolve by priority.
//  - Write/read same channel same cycle: read returns the NEW value (write-through forwarding),
//    including s1_older taking the pre-write s1_last.
//  - Latency: mod_x/mod_y valid 1 clk_en cycle after the slot strobes; group order means S3 reads
//    S2 of the previous sample, S4 reads S3 of the current sample.
//  - Arithmetic: none; pure storage/mux, no width change, sign preserved.
// TESTING
//  - Reset then 48 clk_en: enters sequence S1x6,S3x6,S2x6,S4x6 twice; zero high at clk_en 0 and 24.
//  - clk_en toggled 1/0 alternate: outputs change only on clk_en cycles; period = 48 clk.
//  - Feed op_result=0x100+slot; at ch2 S4 with xuse_internal=1: mod_x = S3 ch2 value 0x10E.
//  - Two samples of S1 ch0 results 0x055 then 0x0AA; xuse_prevprev1,yuse_prev1 -> x=0x055,y=0x0AA.
//  - OP_LAT=NUM_CH: write and read of same channel coincide -> forwarded new value, no stale read.
//  - Assert rst at slot 13 with results pending: next cycle s1_enters=1,cur_ch=0, store all 0.

Source files
------------

// File: rtl/jt12_slot_sched_if.sv
// Slot strobes, operator result and modulation operand bundle between the slot
// scheduler (master) and the operator/modulation-decoder side (slave).
interface jt12_slot_sched_if #(
    parameter int unsigned DW = 14
);
    logic signed [DW-1:0] op_result;
    logic                 xuse_prevprev1;
    logic                 xuse_prev2;
    logic                 xuse_internal;
    logic                 yuse_prev1;
    logic                 yuse_prev2;
    logic                 yuse_internal;
    logic                 s1_enters;
    logic                 s2_enters;
    logic                 s3_enters;
    logic                 s4_enters;
    logic [2:0]           cur_ch;
    logic                 zero;
    logic signed [DW-1:0] mod_x;
    logic signed [DW-1:0] mod_y;

    modport master (
        input  op_result, xuse_prevprev1, xuse_prev2, xuse_internal,
               yuse_prev1, yuse_prev2, yuse_internal,
        output s1_enters, s2_enters, s3_enters, s4_enters, cur_ch, zero, mod_x, mod_y
    );

    modport slave (
        output op_result, xuse_prevprev1, xuse_prev2, xuse_internal,
               yuse_prev1, yuse_prev2, yuse_internal,
        input  s1_enters, s2_enters, s3_enters, s4_enters, cur_ch, zero, mod_x, mod_y
    );
endinterface

// File: rtl/jt12_slot_sched.sv
// Operator slot scheduler: walks groups S1,S3,S2,S4 over NUM_CH channel slots, stores
// recent operator results per channel and returns the decoder-selected x/y operands.
module jt12_slot_sched #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned OP_LAT = 4,
    parameter int unsigned DW     = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    jt12_slot_sched_if.master  bus
);
    localparam int unsigned CW = $clog2(NUM_CH);

    // Encoded in issue order so the group advances by a plain increment.
    typedef enum logic [1:0] {
        G_S1 = 2'd0,
        G_S3 = 2'd1,
        G_S2 = 2'd2,
        G_S4 = 2'd3
    } grp_t;

    typedef struct packed {
        logic          valid;
        grp_t          grp;
        logic [CW-1:0] ch;
    } tag_t;

    grp_t                 grp;
    grp_t                 grp_nxt;
    logic [CW-1:0]        ch;
    logic [CW-1:0]        ch_nxt;
    tag_t [OP_LAT-1:0]    trk;
    tag_t [OP_LAT:0]      trk_shift;
    tag_t                 wr;
    logic signed [DW-1:0] s1_last  [NUM_CH];
    logic signed [DW-1:0] s1_older [NUM_CH];
    logic signed [DW-1:0] s2_last  [NUM_CH];
    logic signed [DW-1:0] s3_last  [NUM_CH];
    logic                 hit_s1;
    logic                 hit_s2;
    logic                 hit_s3;
    logic signed [DW-1:0] rd_s1_last;
    logic signed [DW-1:0] rd_s1_older;
    logic signed [DW-1:0] rd_s2;
    logic signed [DW-1:0] rd_s3;
    logic signed [DW-1:0] x_sel;
    logic signed [DW-1:0] y_sel;

    // Next slot, result tracker shift, and operand reads with write-through forwarding.
    always_comb begin
        ch_nxt  = ch + CW'(1);
        grp_nxt = grp;
        if (ch == CW'(NUM_CH - 1)) begin
            ch_nxt  = '0;
            grp_nxt = grp_t'(2'(grp + 2'd1));
        end

        trk_shift = {trk, tag_t'{valid: 1'b1, grp: grp, ch: ch}};
        wr        = trk[OP_LAT-1];

        hit_s1 = wr.valid && (wr.grp == G_S1) && (wr.ch == ch);
        hit_s2 = wr.valid && (wr.grp == G_S2) && (wr.ch == ch);
        hit_s3 = wr.valid && (wr.grp == G_S3) && (wr.ch == ch);

        rd_s1_last  = hit_s1 ? bus.op_result : s1_last[ch];
        rd_s1_older = hit_s1 ? s1_last[ch]   : s1_older[ch];
        rd_s2       = hit_s2 ? bus.op_result : s2_last[ch];
        rd_s3       = hit_s3 ? bus.op_result : s3_last[ch];

        x_sel = '0;
        if      (bus.xuse_prevprev1) x_sel = rd_s1_older;
        else if (bus.xuse_prev2)     x_sel = rd_s2;
        else if (bus.xuse_internal)  x_sel = rd_s3;

        y_sel = '0;
        if      (bus.yuse_prev1)     y_sel = rd_s1_last;
        else if (bus.yuse_prev2)     y_sel = rd_s2;
        else if (bus.yuse_internal)  y_sel = rd_s3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp           <= G_S1;
            ch            <= '0;
            trk           <= '0;
            s1_last       <= '{default: '0};
            s1_older      <= '{default: '0};
            s2_last       <= '{default: '0};
            s3_last       <= '{default: '0};
            bus.s1_enters <= 1'b1;
            bus.s2_enters <= 1'b0;
            bus.s3_enters <= 1'b0;
            bus.s4_enters <= 1'b0;
            bus.cur_ch    <= '0;
            bus.zero      <= 1'b1;
            bus.mod_x     <= '0;
            bus.mod_y     <= '0;
        end else if (clk_en) begin
            grp           <= grp_nxt;
            ch            <= ch_nxt;
            trk           <= trk_shift[OP_LAT-1:0];
            bus.s1_enters <= (grp_nxt == G_S1);
            bus.s2_enters <= (grp_nxt == G_S2);
            bus.s3_enters <= (grp_nxt == G_S3);
            bus.s4_enters <= (grp_nxt == G_S4);
            bus.cur_ch    <= 3'(ch_nxt);
            bus.zero      <= (grp_nxt == G_S1) && (ch_nxt == '0);
            bus.mod_x     <= x_sel;
            bus.mod_y     <= y_sel;
            // S4 results feed nothing downstream of this block and are dropped.
            if (wr.valid) begin
                case (wr.grp)
                    G_S1: begin
                        s1_older[wr.ch] <= s1_last[wr.ch];
                        s1_last[wr.ch]  <= bus.op_result;
                    end
                    G_S2:    s2_last[wr.ch] <= bus.op_result;
                    G_S3:    s3_last[wr.ch] <= bus.op_result;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jt12_slot_sched.sv
// Directed bench for jt12_slot_sched: slot sequence, clk_en gating, operand
// selection, write-through forwarding (OP_LAT=NUM_CH) and mid-period reset.
module tb_jt12_slot_sched;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    jt12_slot_sched_if #(.DW(14)) if_a ();
    jt12_slot_sched_if #(.DW(14)) if_b ();

    jt12_slot_sched #(.NUM_CH(6), .OP_LAT(4), .DW(14)) dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(if_a)
    );
    jt12_slot_sched #(.NUM_CH(6), .OP_LAT(6), .DW(14)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(if_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // op_result for the slot issued at clk_en index i: 0x100 + group_number*6 + ch.
    function automatic logic [13:0] slot_val(input int i);
        int pos = i % 24;
        int g   = pos / 6;
        int gn  = (g == 1) ? 2 : (g == 2) ? 1 : g;
        return 14'(256 + gn * 6 + pos % 6);
    endfunction

    // Expected {s1,s2,s3,s4,zero,cur_ch} while slot i is presented.
    function automatic logic [7:0] exp_state(input int i);
        int pos = i % 24;
        logic [3:0] en;
        case (pos / 6)
            0:       en = 4'b1000;
            1:       en = 4'b0010;
            2:       en = 4'b0100;
            default: en = 4'b0001;
        endcase
        return {en, 1'(pos == 0), 3'(pos % 6)};
    endfunction

    function automatic logic [7:0] state_a();
        return {if_a.s1_enters, if_a.s2_enters, if_a.s3_enters, if_a.s4_enters,
                if_a.zero, if_a.cur_ch};
    endfunction

    task automatic set_flags(input logic [5:0] f);
        {if_a.xuse_prevprev1, if_a.xuse_prev2, if_a.xuse_internal,
         if_a.yuse_prev1, if_a.yuse_prev2, if_a.yuse_internal} = f;
        {if_b.xuse_prevprev1, if_b.xuse_prev2, if_b.xuse_internal,
         if_b.yuse_prev1, if_b.yuse_prev2, if_b.yuse_internal} = f;
    endtask

    // One clock: drive inputs for clk_en index n, then sample 1 time unit after the edge.
    task automatic step(input logic ce);
        clk_en = ce;
        if (n == 4)       if_a.op_result = 14'h055;
        else if (n == 28) if_a.op_result = 14'h0AA;
        else if (n >= 4)  if_a.op_result = slot_val(n - 4);
        else              if_a.op_result = 14'h3FF;
        if_b.op_result = (n >= 6) ? 14'(512 + n - 6) : 14'h3FF;
        @(posedge clk);
        #1;
        if (ce) n++;
    endtask

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_PP1   = 6'b100100;  // xuse_prevprev1, yuse_prev1
    localparam logic [5:0] F_INT2  = 6'b001010;  // xuse_internal, yuse_prev2
    localparam logic [5:0] F_INT1  = 6'b001100;  // xuse_internal, yuse_prev1

    initial begin
        rst = 1'b1;
        clk_en = 1'b0;
        n = 0;
        set_flags(F_NONE);
        if_a.op_result = '0;
        if_b.op_result = '0;
        @(negedge clk);
        step(1'b1);
        rst = 1'b0;
        n = 0;
        check("reset_state", 32'(state_a()), 32'h88);
        check("reset_mod", {if_a.mod_x, if_a.mod_y}, 32'h0);

        // Two full sample periods plus a few slots, with operand reads at chosen slots.
        for (int k = 0; k < 52; k++) begin
            case (k)
                20:      set_flags(F_INT2);
                30, 48:  set_flags(F_PP1);
                default: set_flags(F_NONE);
            endcase
            step(1'b1);
            if (k < 48) check($sformatf("seq_%0d", k + 1), 32'(state_a()), 32'(exp_state(k + 1)));
            if (k == 20) begin
                check("s4_x_s3_cur", 32'(if_a.mod_x), 32'h10E);
                check("s4_y_s2_last", 32'(if_a.mod_y), 32'h108);
            end
            if (k == 21) check("no_flag_mod", {if_a.mod_x, if_a.mod_y}, 32'h0);
            if (k == 30) begin
                check("fwd_x_older", 32'(if_b.mod_x), 32'h200);
                check("fwd_y_new", 32'(if_b.mod_y), 32'h218);
                check("s3_x_older", 32'(if_a.mod_x), 32'h055);
                check("s3_y_last", 32'(if_a.mod_y), 32'h0AA);
            end
            if (k == 48) begin
                check("s1_x_older", 32'(if_a.mod_x), 32'h055);
                check("s1_y_last", 32'(if_a.mod_y), 32'h0AA);
            end
        end

        // clk_en alternating: state must move only on enabled cycles.
        set_flags(F_NONE);
        for (int i = 0; i < 8; i++) begin
            step(1'(i % 2 == 0));
            check($sformatf("ce_gate_%0d", i), 32'(state_a()), 32'(exp_state(n)));
        end

        // Run to slot 13 of the period, then reset with results in flight.
        while (n % 24 != 13) step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        n = 0;
        check("midrst_state", 32'(state_a()), 32'h88);
        check("midrst_mod", {if_a.mod_x, if_a.mod_y}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_flags(F_INT1);
            step(1'b1);
            check($sformatf("cleared_ch%0d", k), {if_a.mod_x, if_a.mod_y}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
